fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe_pkg.sv | 49 ++++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_pipe.sv | 245 ++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point adder/subtractor:
// rounding modes, error flag positions, operand classification and canonical NaN.
package addpkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

    localparam int ERR_INVALID   = 0;
    localparam int ERR_OVERFLOW  = 1;
    localparam int ERR_UNDERFLOW = 2;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'b00,
        CLS_NORMAL = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    typedef struct packed {
        logic      sign;
        fp_class_e cls;
    } fp_unpacked_t;

    // Subnormals (zero exponent, nonzero fraction) are classed as zero.
    function automatic fp_unpacked_t classify(input logic sign, input logic exp_zero,
                                              input logic exp_ones, input logic man_zero);
        fp_unpacked_t u;
        u.sign = sign;
        if (exp_zero)      u.cls = CLS_ZERO;
        else if (!exp_ones) u.cls = CLS_NORMAL;
        else if (man_zero) u.cls = CLS_INF;
        else               u.cls = CLS_NAN;
        return u;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Ascending scan so the highest set bit has the final say.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: align, add+normalize, round+pack.
// Single global stall: any held output freezes every stage.
module fp_addsub_pipe
    import addpkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       opcode,
    input  logic [1:0]                 rmode,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       fp_out,
    output logic [2:0]                 err_o,
    output logic [TAG_W-1:0]           tag_o
);

    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;
    localparam int SUM_W = SIG_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int LZW   = $clog2(SIG_W + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [FP_W-1:0]  NAN_VAL  = FP_W'(canon_nan(EXP_W, MAN_W));

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the only back-pressure source is a result held by out_ready=0.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp, ax, bx, x_exp, y_exp, diff;
    logic [MAN_W-1:0]   a_man, b_man;
    logic [MAN_W:0]     as_sig, bs_sig, x_sig, y_sig;
    fp_unpacked_t       ua, ub;
    logic               eff_sub, a_ge_b, x_sign, nan_1, inf_1, inf_sign_1, lost;
    logic [SIG_W-1:0]   y_ext, y_sh, y_al;

    assign {a_sign, a_exp, a_man} = a;
    assign {b_sign, b_exp, b_man} = b;
    assign ua = classify(a_sign, a_exp == '0, &a_exp, a_man == '0);
    assign ub = classify(b_sign ^ opcode, b_exp == '0, &b_exp, b_man == '0);
    assign eff_sub = ua.sign ^ ub.sign;

    assign ax     = (ua.cls == CLS_NORMAL) ? a_exp : '0;
    assign bx     = (ub.cls == CLS_NORMAL) ? b_exp : '0;
    assign as_sig = (ua.cls == CLS_NORMAL) ? {1'b1, a_man} : '0;
    assign bs_sig = (ub.cls == CLS_NORMAL) ? {1'b1, b_man} : '0;
    assign a_ge_b = {ax, as_sig} >= {bx, bs_sig};
    assign x_exp  = a_ge_b ? ax : bx;
    assign y_exp  = a_ge_b ? bx : ax;
    assign x_sig  = a_ge_b ? as_sig : bs_sig;
    assign y_sig  = a_ge_b ? bs_sig : as_sig;
    assign x_sign = a_ge_b ? ua.sign : ub.sign;
    assign diff   = x_exp - y_exp;

    // Everything shifted below the sticky position is OR-folded into it.
    assign y_ext = {y_sig, 3'b000};
    assign y_sh  = y_ext >> diff;
    assign lost  = |(y_ext & ~({SIG_W{1'b1}} << diff));
    assign y_al  = (32'(diff) >= 32'(SIG_W - 1)) ? {{(SIG_W-1){1'b0}}, |y_sig}
                                                 : {y_sh[SIG_W-1:1], y_sh[0] | lost};

    assign nan_1 = (ua.cls == CLS_NAN) || (ub.cls == CLS_NAN) ||
                   ((ua.cls == CLS_INF) && (ub.cls == CLS_INF) && eff_sub);
    assign inf_1 = (ua.cls == CLS_INF) || (ub.cls == CLS_INF);
    assign inf_sign_1 = (ua.cls == CLS_INF) ? ua.sign : ub.sign;

    logic             s1_valid, s1_nan, s1_inf, s1_sign, s1_eff_sub;
    logic [TAG_W-1:0] s1_tag;
    rmode_e           s1_rmode;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_mx, s1_my;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_rmode   <= RM_RNE;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_exp     <= '0;
            s1_mx      <= '0;
            s1_my      <= '0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_tag     <= tag_i;
            s1_rmode   <= rmode_e'(rmode);
            s1_nan     <= nan_1;
            s1_inf     <= inf_1;
            s1_sign    <= inf_1 ? inf_sign_1 : x_sign;
            s1_eff_sub <= eff_sub;
            s1_exp     <= x_exp;
            s1_mx      <= {x_sig, 3'b000};
            s1_my      <= y_al;
        end
    end

    // ---------------- S2: add/subtract, LZC, normalize ----------------
    logic [SUM_W-1:0] sum;
    logic [LZW-1:0]   lz;
    logic [SIG_W-1:0] norm;
    logic [EW-1:0]    exp_n;
    logic             sum_zero, tiny_2;

    assign sum = s1_eff_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                            : ({1'b0, s1_mx} + {1'b0, s1_my});
    assign sum_zero = (sum == '0);

    fp_lzc #(.W(SIG_W), .CW(LZW)) u_lzc (
        .value(sum[SIG_W-1:0]),
        .count(lz)
    );

    always_comb begin
        norm  = '0;
        exp_n = '0;
        if (sum[SUM_W-1]) begin
            norm  = {sum[SUM_W-1:2], sum[1] | sum[0]};
            exp_n = EW'(s1_exp) + EW'(1);
        end else begin
            norm  = sum[SIG_W-1:0] << lz;
            exp_n = EW'(s1_exp) - EW'(lz);
        end
    end
    // A biased exponent of zero or below cannot be represented without subnormals.
    assign tiny_2 = exp_n[EW-1] | (exp_n == '0);

    logic             s2_valid, s2_nan, s2_inf, s2_zero, s2_tiny, s2_sign, s2_eff_sub;
    logic [TAG_W-1:0] s2_tag;
    rmode_e           s2_rmode;
    logic [EW-1:0]    s2_exp;
    logic [SIG_W-1:0] s2_sig;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_tag     <= '0;
            s2_rmode   <= RM_RNE;
            s2_nan     <= 1'b0;
            s2_inf     <= 1'b0;
            s2_zero    <= 1'b0;
            s2_tiny    <= 1'b0;
            s2_sign    <= 1'b0;
            s2_eff_sub <= 1'b0;
            s2_exp     <= '0;
            s2_sig     <= '0;
        end else if (!stall) begin
            s2_valid   <= s1_valid;
            s2_tag     <= s1_tag;
            s2_rmode   <= s1_rmode;
            s2_nan     <= s1_nan;
            s2_inf     <= s1_inf;
            s2_zero    <= sum_zero;
            s2_tiny    <= tiny_2;
            s2_sign    <= s1_sign;
            s2_eff_sub <= s1_eff_sub;
            s2_exp     <= exp_n;
            s2_sig     <= norm;
        end
    end

    // ---------------- S3: round, renormalize, exceptions, pack ----------------
    logic               round_up, inexact, ovf, zero_sign, inf_dir;
    logic [MAN_W+1:0]   rnd;
    logic [MAN_W-1:0]   man_r;
    logic [EW-1:0]      exp_r;
    logic [FP_W-1:0]    res;
    logic [2:0]         err;

    assign inexact = |s2_sig[2:0];

    always_comb begin
        round_up = 1'b0;
        case (s2_rmode)
            RM_RNE: round_up = s2_sig[2] & (s2_sig[1] | s2_sig[0] | s2_sig[3]);
            RM_RTZ: round_up = 1'b0;
            RM_RUP: round_up = inexact & ~s2_sig_sign_dummy(s2_sign);
            RM_RDN: round_up = inexact & s2_sign;
            default: round_up = 1'b0;
        endcase
    end

    function automatic logic s2_sig_sign_dummy(input logic s);
        return s;
    endfunction

    assign rnd   = {1'b0, s2_sig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    assign man_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    assign exp_r = rnd[MAN_W+1] ? (s2_exp + EW'(1)) : s2_exp;
    assign ovf   = exp_r >= {2'b00, EXP_ONES};
    assign zero_sign = s2_eff_sub ? (s2_rmode == RM_RDN) : s2_sign;
    // Overflow saturates to infinity only when rounding points away from zero.
    assign inf_dir = (s2_rmode == RM_RNE) || ((s2_rmode == RM_RUP) && !s2_sign) ||
                     ((s2_rmode == RM_RDN) && s2_sign);

    always_comb begin
        res = '0;
        err = '0;
        if (s2_nan) begin
            res = NAN_VAL;
            err[ERR_INVALID] = 1'b1;
        end else if (s2_inf) begin
            res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res = {zero_sign, {(FP_W-1){1'b0}}};
        end else if (s2_tiny) begin
            res = {s2_sign, {(FP_W-1){1'b0}}};
            err[ERR_UNDERFLOW] = 1'b1;
        end else if (ovf) begin
            res = inf_dir ? {s2_sign, EXP_ONES, {MAN_W{1'b0}}}
                          : {s2_sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
            err[ERR_OVERFLOW] = 1'b1;
        end else begin
            res = {s2_sign, exp_r[EXP_W-1:0], man_r};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            fp_out    <= '0;
            err_o     <= '0;
            tag_o     <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            fp_out    <= res;
            err_o     <= err;
            tag_o     <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe: a driver pushes hand-computed results
// into a queue at acceptance, a monitor pops and compares on each output transfer.
module tb_fp_addsub_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int QW    = TAG_W + 3 + FP_W;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             opcode = 1'b0;
    logic [1:0]       rmode = 2'b00;
    logic [FP_W-1:0]  a = '0;
    logic [FP_W-1:0]  b = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [FP_W-1:0]  fp_out;
    logic [2:0]       err_o;
    logic [TAG_W-1:0] tag_o;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rmode(rmode), .a(a), .b(b), .tag_i(tag_i),
        .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out),
        .err_o(err_o), .tag_o(tag_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [QW-1:0]    exp_q[$];
    int               acc_q[$];
    bit               lat_q[$];
    int               passed = 0;
    int               total = 0;
    logic [TAG_W-1:0] next_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) $display("FAIL %s: actual=%h required=%h", name, act, req);
        else passed++;
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic op, input logic [1:0] rm, input logic [FP_W-1:0] va,
                        input logic [FP_W-1:0] vb, input logic [FP_W-1:0] efp,
                        input logic [2:0] eerr, input bit push, input bit lat);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        opcode   = op;
        rmode    = rm;
        a        = va;
        b        = vb;
        tag_i    = next_tag;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: actual=in_ready low for %0d cycles required=accept", guard);
        end else if (push) begin
            exp_q.push_back({next_tag, eerr, efp});
            acc_q.push_back(cyc);
            lat_q.push_back(lat);
        end
        next_tag = next_tag + 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic [QW-1:0] held;
    bit            held_v = 1'b0;

    always @(negedge clk) begin
        logic [QW-1:0] e;
        int            acc;
        bit            lat;
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold_stable", 64'({tag_o, err_o, fp_out}), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out: actual=result tag %0d required=no result", tag_o);
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    lat = lat_q.pop_front();
                    check("fp_out", 64'(fp_out), 64'(e[FP_W-1:0]));
                    check("err_o", 64'(err_o), 64'(e[FP_W+2:FP_W]));
                    check("tag_o", 64'(tag_o), 64'(e[QW-1:FP_W+3]));
                    if (lat) check("latency", 64'(cyc - acc), 64'd3);
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held_v = 1'b1;
                held   = {tag_o, err_o, fp_out};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit saw_low;
    int seen_v;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({tag_o, err_o, fp_out}), 64'd0);
        @(posedge clk);
        #1;

        // Basic arithmetic, one at a time so latency is exact.
        send(1'b0, RNE, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 1, 1);
        drain();
        send(1'b1, RNE, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 1, 1);
        drain();
        send(1'b1, RDN, 32'h3F800000, 32'h3F800000, 32'h80000000, 3'b000, 1, 1);
        drain();

        // Back-to-back specials, overflow and rounding boundaries.
        send(1'b1, RNE, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 1, 1);
        send(1'b0, RNE, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 1, 1);
        send(1'b0, RTZ, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b010, 1, 1);
        send(1'b0, RUP, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 1, 1);
        send(1'b0, RDN, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b010, 1, 1);
        send(1'b0, RDN, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 3'b010, 1, 1);
        send(1'b0, RNE, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 3'b010, 1, 1);
        send(1'b0, RTZ, 32'h7F7FFFFF, 32'h73000000, 32'h7F7FFFFF, 3'b000, 1, 1);
        send(1'b0, RNE, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 1, 1);
        send(1'b0, RUP, 32'h3F800000, 32'h33800000, 32'h3F800001, 3'b000, 1, 1);
        send(1'b0, RNE, 32'h3F800000, 32'h33C00000, 32'h3F800001, 3'b000, 1, 1);
        send(1'b0, RTZ, 32'h3F800000, 32'h33C00000, 32'h3F800000, 3'b000, 1, 1);
        send(1'b0, RNE, 32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000, 1, 1);
        send(1'b0, RUP, 32'h3F800000, 32'h30800000, 32'h3F800001, 3'b000, 1, 1);
        send(1'b1, RTZ, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 3'b000, 1, 1);
        send(1'b1, RNE, 32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000, 1, 1);
        send(1'b0, RNE, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000, 1, 1);
        send(1'b1, RNE, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 1, 1);
        send(1'b0, RNE, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1, 1);
        send(1'b1, RTZ, 32'h3F800000, 32'h7F800001, 32'h7FC00000, 3'b001, 1, 1);
        send(1'b0, RNE, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000, 1, 1);
        send(1'b1, RNE, 32'h00800000, 32'h00C00000, 32'h80000000, 3'b100, 1, 1);
        send(1'b1, RNE, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000, 1, 1);
        send(1'b0, RNE, 32'h3FC00000, 32'h40200000, 32'h40800000, 3'b000, 1, 1);
        drain();

        // Back-pressure: four tagged ops while the consumer stalls for five cycles.
        out_ready = 1'b0;
        saw_low   = 1'b0;
        fork
            begin
                send(1'b0, RNE, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 1, 0);
                send(1'b0, RNE, 32'h3FC00000, 32'h40200000, 32'h40800000, 3'b000, 1, 0);
                send(1'b1, RNE, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000, 1, 0);
                send(1'b1, RDN, 32'h3F800000, 32'h3F800000, 32'h80000000, 3'b000, 1, 0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1'b1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("stall_in_ready_low", 64'(saw_low), 64'd1);
        drain();

        // Reset with three ops in flight and a fourth presented during reset.
        out_ready = 1'b0;
        send(1'b0, RNE, 32'h3F800000, 32'h3F800000, 32'h0, 3'b000, 0, 0);
        send(1'b0, RNE, 32'h40000000, 32'h40000000, 32'h0, 3'b000, 0, 0);
        send(1'b0, RNE, 32'h40400000, 32'h40400000, 32'h0, 3'b000, 0, 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_outputs", 64'({out_valid, tag_o, err_o, fp_out}), 64'd0);
        seen_v = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen_v++;
        end
        check("post_rst_no_out", 64'(seen_v), 64'd0);
        @(posedge clk);
        #1;
        send(1'b0, RNE, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 1, 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
